// File: rtl/rtc_timer.sv
// rtc_timer: prescaled tick counter with programmable one-shot/periodic alarms.
// Word-addressed register interface, level interrupt from STATUS & IRQ_EN.
module rtc_timer #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int CNT_W    = 32,
    parameter int N_ALARMS = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       addr_i,
    input  logic [31:0]      wdata_i,
    input  logic             we_i,
    input  logic             re_i,
    output logic [31:0]      rdata_o,
    output logic             tick_o,
    output logic             irq_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0]       presc_q;
    logic [CNT_W-1:0]    count_q;
    logic                en_q;
    logic [N_ALARMS-1:0] arm_q;
    logic [N_ALARMS:0]   status_q;
    logic [N_ALARMS:0]   irq_en_q;
    logic [CNT_W-1:0]    cmp_q    [N_ALARMS];
    logic [CNT_W-1:0]    period_q [N_ALARMS];

    logic                wr_count, wr_ctrl, wr_status, wr_irq_en;
    logic [N_ALARMS-1:0] wr_cmp, wr_period;
    logic                presc_wrap;
    logic                tick_fire;
    logic [CNT_W-1:0]    cnt_next;
    logic [N_ALARMS-1:0] fire;
    logic [N_ALARMS-1:0] oneshot_fire;
    logic                ovf_set;
    logic [31:0]         rd_val;

    // Register write decode
    always_comb begin
        wr_count  = we_i && (addr_i == 6'h00);
        wr_ctrl   = we_i && (addr_i == 6'h01);
        wr_status = we_i && (addr_i == 6'h02);
        wr_irq_en = we_i && (addr_i == 6'h03);
        wr_cmp    = '0;
        wr_period = '0;
        for (int k = 0; k < N_ALARMS; k++) begin
            wr_cmp[k]    = we_i && (addr_i == 6'(4 + 2 * k));
            wr_period[k] = we_i && (addr_i == 6'(5 + 2 * k));
        end
    end

    // Tick generation: a COUNT write in the wrap cycle swallows that tick
    always_comb begin
        presc_wrap = en_q && (presc_q == PRESC_LAST);
        tick_fire  = presc_wrap && !wr_count;
        cnt_next   = count_q + CNT_W'(1);
        ovf_set    = tick_fire && (count_q == {CNT_W{1'b1}});
    end

    // Alarm compare against the post-increment counter, all channels in parallel
    always_comb begin
        fire         = '0;
        oneshot_fire = '0;
        for (int k = 0; k < N_ALARMS; k++) begin
            fire[k]         = tick_fire && arm_q[k] && (cnt_next == cmp_q[k]);
            oneshot_fire[k] = fire[k] && (period_q[k] == '0);
        end
    end

    // Prescaler and tick counter; a COUNT write restarts the tick period
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
            count_q <= '0;
        end else if (wr_count) begin
            presc_q <= '0;
            count_q <= wdata_i[CNT_W-1:0];
        end else if (en_q) begin
            presc_q <= presc_wrap ? '0 : presc_q + PW'(1);
            if (tick_fire) count_q <= cnt_next;
        end
    end

    // Control, status and interrupt-enable; hardware set beats W1C, CTRL write beats one-shot disarm
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q     <= 1'b0;
            arm_q    <= '0;
            status_q <= '0;
            irq_en_q <= '0;
        end else begin
            if (wr_ctrl) begin
                en_q  <= wdata_i[0];
                arm_q <= wdata_i[N_ALARMS:1];
            end else begin
                arm_q <= arm_q & ~oneshot_fire;
            end
            status_q <= (wr_status ? (status_q & ~wdata_i[N_ALARMS:0]) : status_q)
                        | {ovf_set, fire};
            if (wr_irq_en) irq_en_q <= wdata_i[N_ALARMS:0];
        end
    end

    // Compare and period registers; software CMP write beats periodic reload
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_ALARMS; k++) begin
                cmp_q[k]    <= '0;
                period_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_ALARMS; k++) begin
                if (wr_cmp[k]) begin
                    cmp_q[k] <= wdata_i[CNT_W-1:0];
                end else if (fire[k] && (period_q[k] != '0)) begin
                    cmp_q[k] <= cmp_q[k] + period_q[k];
                end
                if (wr_period[k]) period_q[k] <= wdata_i[CNT_W-1:0];
            end
        end
    end

    // Read mux; unmapped addresses and unused bits return 0
    always_comb begin
        rd_val = '0;
        case (addr_i)
            6'h00:   rd_val[CNT_W-1:0]  = count_q;
            6'h01:   rd_val[N_ALARMS:0] = {arm_q, en_q};
            6'h02:   rd_val[N_ALARMS:0] = status_q;
            6'h03:   rd_val[N_ALARMS:0] = irq_en_q;
            default: begin
                for (int k = 0; k < N_ALARMS; k++) begin
                    if (addr_i == 6'(4 + 2 * k)) rd_val[CNT_W-1:0] = cmp_q[k];
                    if (addr_i == 6'(5 + 2 * k)) rd_val[CNT_W-1:0] = period_q[k];
                end
            end
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= rd_val;
        end
    end

    assign tick_o  = tick_fire;
    assign irq_o   = |(status_q & irq_en_q);
    assign count_o = count_q;

endmodule

// File: tb/tb_rtc_timer.sv
// Directed testbench for rtc_timer with DIV=10, CNT_W=8, two alarm channels.
module tb_rtc_timer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [5:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        we_i = 1'b0;
    logic        re_i = 1'b0;
    logic [31:0] rdata_o;
    logic        tick_o;
    logic        irq_o;
    logic [7:0]  count_o;

    int vectors = 0;
    int miscompares = 0;
    int gap;
    logic [31:0] rv;

    rtc_timer #(
        .CLK_FREQ(10_000),
        .TICK_HZ (1000),
        .CNT_W   (8),
        .N_ALARMS(2)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .we_i   (we_i),
        .re_i   (re_i),
        .rdata_o(rdata_o),
        .tick_o (tick_o),
        .irq_o  (irq_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        addr_i  = a;
        wdata_i = d;
        we_i    = 1'b1;
        step();
        we_i    = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        addr_i = a;
        re_i   = 1'b1;
        step();
        re_i   = 1'b0;
        d      = rdata_o;
    endtask

    // Advance until tick_o is high; gap=1 is the cycle right after the last edge of interest
    task automatic wait_tick(output int g);
        g = 1;
        while (tick_o !== 1'b1 && g < 40) begin
            step();
            g++;
        end
        chk("tick_seen", {31'd0, tick_o}, 32'd1);
    endtask

    task automatic ticks(input int n);
        int g;
        for (int i = 0; i < n; i++) begin
            wait_tick(g);
            step();
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_count", {24'd0, count_o}, 32'h0);
        chk("rst_tick", {31'd0, tick_o}, 32'h0);
        chk("rst_irq", {31'd0, irq_o}, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        rst_i = 1'b0;
        step();

        // Enable: first tick 10 cycles after the write, then every 10
        wr(6'h01, 32'h1);
        wait_tick(gap);
        chk("first_tick_gap", gap, 32'd10);
        chk("count_at_tick0", {24'd0, count_o}, 32'h00);
        step();
        chk("count_after_tick0", {24'd0, count_o}, 32'h01);
        chk("tick_one_cycle", {31'd0, tick_o}, 32'h0);
        wait_tick(gap);
        chk("tick_period", gap, 32'd10);
        step();
        chk("count_after_tick1", {24'd0, count_o}, 32'h02);
        chk("irq_idle", {31'd0, irq_o}, 32'h0);

        // Overflow flag and interrupt
        wr(6'h00, 32'hFE);
        wr(6'h03, 32'h4);
        wait_tick(gap);
        chk("count_fe", {24'd0, count_o}, 32'hFE);
        step();
        chk("count_ff", {24'd0, count_o}, 32'hFF);
        chk("irq_pre_wrap", {31'd0, irq_o}, 32'h0);
        ticks(1);
        chk("count_wrap", {24'd0, count_o}, 32'h00);
        chk("irq_ovf", {31'd0, irq_o}, 32'h1);
        rd(6'h02, rv);
        chk("status_ovf", rv, 32'h4);
        wr(6'h02, 32'h4);
        chk("irq_cleared", {31'd0, irq_o}, 32'h0);

        // One-shot alarm 0 at count 5
        wr(6'h04, 32'h5);
        wr(6'h05, 32'h0);
        wr(6'h03, 32'h1);
        wr(6'h01, 32'h3);
        wr(6'h00, 32'h0);
        ticks(5);
        chk("os_count", {24'd0, count_o}, 32'h05);
        chk("os_irq", {31'd0, irq_o}, 32'h1);
        rd(6'h02, rv);
        chk("os_status", rv, 32'h1);
        rd(6'h01, rv);
        chk("os_disarmed", rv, 32'h1);
        wr(6'h02, 32'h1);
        wr(6'h00, 32'hFE);
        ticks(7);
        chk("os_count_again", {24'd0, count_o}, 32'h05);
        rd(6'h02, rv);
        chk("os_no_refire", rv, 32'h4);
        chk("os_irq_masked", {31'd0, irq_o}, 32'h0);
        wr(6'h02, 32'h7);

        // Periodic alarm 1: CMP=3, PERIOD=4
        wr(6'h06, 32'h3);
        wr(6'h07, 32'h4);
        wr(6'h01, 32'h5);
        wr(6'h03, 32'h2);
        wr(6'h00, 32'h0);
        ticks(3);
        rd(6'h02, rv);
        chk("per_status3", rv, 32'h2);
        rd(6'h06, rv);
        chk("per_cmp7", rv, 32'h7);
        rd(6'h01, rv);
        chk("per_armed", rv, 32'h5);
        ticks(3);
        wait_tick(gap);
        chk("per_count6", {24'd0, count_o}, 32'h06);
        wr(6'h02, 32'h2);
        chk("per_count7", {24'd0, count_o}, 32'h07);
        rd(6'h02, rv);
        chk("per_set_beats_w1c", rv, 32'h2);
        chk("per_irq", {31'd0, irq_o}, 32'h1);
        rd(6'h06, rv);
        chk("per_cmp11", rv, 32'h0B);
        wr(6'h02, 32'h2);
        chk("per_irq_clr", {31'd0, irq_o}, 32'h0);
        ticks(4);
        chk("per_count11", {24'd0, count_o}, 32'h0B);
        rd(6'h02, rv);
        chk("per_status11", rv, 32'h2);
        rd(6'h06, rv);
        chk("per_cmp15", rv, 32'h0F);

        // COUNT write on the wrap cycle suppresses the tick
        wait_tick(gap);
        chk("cw_pre_count", {24'd0, count_o}, 32'h0B);
        addr_i  = 6'h00;
        wdata_i = 32'h40;
        we_i    = 1'b1;
        #1;
        chk("cw_tick_suppressed", {31'd0, tick_o}, 32'h0);
        step();
        we_i = 1'b0;
        chk("cw_count_loaded", {24'd0, count_o}, 32'h40);
        wait_tick(gap);
        chk("cw_next_tick_gap", gap, 32'd10);
        chk("cw_count_at_tick", {24'd0, count_o}, 32'h40);
        step();

        // COUNT write equal to CMP[0] does not fire
        wr(6'h04, 32'h60);
        wr(6'h05, 32'h0);
        wr(6'h02, 32'h7);
        wr(6'h01, 32'h3);
        wr(6'h00, 32'h60);
        step();
        rd(6'h02, rv);
        chk("cw_no_fire", rv, 32'h0);
        rd(6'h01, rv);
        chk("cw_still_armed", rv, 32'h3);
        ticks(1);
        chk("cw_count61", {24'd0, count_o}, 32'h61);
        rd(6'h02, rv);
        chk("cw_no_fire61", rv, 32'h0);

        // Asynchronous reset mid-run with irq pending
        wr(6'h03, 32'h4);
        wr(6'h00, 32'hFF);
        ticks(1);
        chk("ar_count_wrap", {24'd0, count_o}, 32'h00);
        chk("ar_irq_high", {31'd0, irq_o}, 32'h1);
        rd(6'h03, rv);
        chk("ar_rdata_pre", rv, 32'h4);
        rst_i = 1'b1;
        #1;
        chk("ar_count", {24'd0, count_o}, 32'h0);
        chk("ar_irq", {31'd0, irq_o}, 32'h0);
        chk("ar_tick", {31'd0, tick_o}, 32'h0);
        chk("ar_rdata", rdata_o, 32'h0);
        step();
        rst_i = 1'b0;
        rd(6'h2A, rv);
        chk("ar_unmapped", rv, 32'h0);
        rd(6'h02, rv);
        chk("ar_status", rv, 32'h0);
        rd(6'h01, rv);
        chk("ar_ctrl", rv, 32'h0);
        rd(6'h04, rv);
        chk("ar_cmp0", rv, 32'h0);
        rd(6'h03, rv);
        chk("ar_irq_en", rv, 32'h0);
        for (int i = 0; i < 15; i++) step();
        chk("ar_count_held", {24'd0, count_o}, 32'h0);
        chk("ar_tick_idle", {31'd0, tick_o}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rtc_timer.md
Name: rtc_timer

Overview:
Parametrised real-time tick counter with N programmable alarm channels, replacing the fixed 1 ms counter. A prescaler divides clk_i down to TICK_HZ and advances a CNT_W-bit tick counter. Each alarm compares against the counter and can run one-shot or periodic. The block sits on the CPU peripheral bus, with a word-addressed register interface and a single level interrupt to the interrupt controller.

Parameters:
CLK_FREQ, 50_000_000, input clock frequency in Hz
TICK_HZ, 1000, tick rate in Hz; DIV = CLK_FREQ/TICK_HZ; CLK_FREQ % TICK_HZ == 0 and DIV >= 2 are required
CNT_W, 32, tick counter width, 8..32
N_ALARMS, 4, number of alarm channels, 1..8

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
addr_i  in  6  word address
wdata_i  in  32  write data
we_i  in  1  write strobe, one access per cycle
re_i  in  1  read strobe
rdata_o  out  32  read data, registered
tick_o  out  1  one-cycle pulse on every counter increment
irq_o  out  1  level interrupt, equal to |(STATUS & IRQ_EN)
count_o  out  CNT_W  current tick counter value

Behaviour:
- Reset: prescaler=0, COUNT=0, CTRL=0, STATUS=0, IRQ_EN=0, all CMP/PERIOD=0, rdata_o=0, tick_o=0. irq_o=0 because STATUS is 0.
- Register map (word addresses):
  - 0x00 COUNT: RW.
  - 0x01 CTRL: bit0 EN; bit 1+k ARM[k].
  - 0x02 STATUS: bit k ALARM[k], bit N_ALARMS OVF. W1C.
  - 0x03 IRQ_EN: same layout as STATUS.
  - 0x04+2k CMP[k].
  - 0x05+2k PERIOD[k].
  - Unmapped or unused bits read 0. Writes to unmapped addresses are ignored. CNT_W-wide registers use the low bits of wdata_i.
- Reads: rdata_o is valid the cycle after re_i and holds its value until the next read.
- Prescaler (EN=1): counts 0..DIV-1. At DIV-1 it returns to 0, COUNT <= COUNT+1 mod 2^CNT_W, and tick_o=1 for exactly that cycle.
- Prescaler (EN=0): prescaler and COUNT hold; tick_o=0.
- Wrap: a tick taking COUNT from 2^CNT_W-1 to 0 sets STATUS.OVF.
- COUNT write: loads COUNT, clears the prescaler, and suppresses any tick in the same cycle (write wins). The first tick after the write comes DIV cycles later.
- Alarm k fires on a tick when ARM[k]=1 and the new counter value equals CMP[k]. On fire, STATUS.ALARM[k] is set in the same clock edge as the COUNT update.
  - One-shot (PERIOD[k]=0): the fire clears ARM[k].
  - Periodic (PERIOD[k]!=0): CMP[k] <= CMP[k]+PERIOD[k] mod 2^CNT_W, and ARM stays set.
- All alarms are evaluated in parallel, so several may fire on the same tick.
- Hardware set beats software clear: if a W1C to STATUS and a fire hit the same bit in the same cycle, the bit ends up 1.
- If a CTRL write and a one-shot fire coincide, the CTRL write value wins for ARM.
- A CMP/PERIOD write takes effect for ticks from the next cycle onward. If a CMP write and a periodic reload of that channel coincide, the software write wins.
- COUNT writes never fire alarms. Only ticks are compared.
- irq_o is combinational from registered STATUS and IRQ_EN. It stays high until every enabled pending bit is cleared.
- rst_i asserted mid-count returns the block to the reset state immediately.

Test Plan:
- Bench parameters CLK_FREQ=10_000, TICK_HZ=1000 (DIV=10), CNT_W=8, N_ALARMS=2. Release reset, write CTRL=1 -> first tick_o exactly 10 cycles after the write, then every 10 cycles; count_o increments by 1 per tick; irq_o stays 0.
- Write COUNT=0xFE, IRQ_EN=0x4 -> ticks take COUNT FE->FF->00; on the 00 tick STATUS=0x4 and irq_o=1. Write STATUS=0x4 -> irq_o=0 the next cycle.
- CMP[0]=5, PERIOD[0]=0, CTRL=0x3, IRQ_EN=0x1, COUNT=0 -> ALARM[0] set on the tick to 5, ARM[0] reads 0, and there is no refire at 5 after wrap.
- CMP[1]=3, PERIOD[1]=4, CTRL=0x5 -> ALARM[1] fires at counts 3, 7, 11, and CMP[1] reads 7 after the first fire. W1C issued on a fire cycle leaves STATUS bit 1 set.
- COUNT write landing on the prescaler's DIV-1 cycle -> no tick that cycle, COUNT equals the written value, next tick 10 cycles later. Write COUNT=CMP[0] with ARM[0]=1 -> no fire.
- Assert rst_i mid-run with irq_o=1 -> all outputs and registers 0 immediately; read of 0x2A returns 0.
